// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared types and constants for the programmable serial sequence detector.
//   state_t     : detector state (IDLE = no valid config, RUN = detecting)
//   DEF_PATTERN : power-on pattern, 'b1110, zero-extended into the pattern field
//   DEF_LEN     : power-on pattern length
package seq_detect_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] DEF_PATTERN = 32'b1110;
  localparam int          DEF_LEN     = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its maximum value instead of wrapping.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears the count
//   inc : add one this cycle (ignored once the count is all ones)
//   clr : synchronous clear, takes priority over inc
//   cnt : current count, W bits
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
// Programmable serial sequence detector with a registered (Moore-style) match
// pulse. Pattern, length and overlap mode are loaded at run time.
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   cfg_load     : one-cycle strobe capturing cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  : pattern, bit [cfg_len-1] is the first bit on the wire
//   cfg_len      : pattern length, valid range 1..MAX_LEN
//   cfg_overlap  : 1 = matches may share bits, 0 = history flushed on a match
//   din_valid    : qualifies din
//   din          : serial data bit
//   cnt_clr      : synchronous clear of match_cnt (wins over an increment)
//   dout         : one-cycle match pulse, one cycle after the completing bit
//   match_cnt    : saturating match count
//   cfg_err      : sticky, last load was invalid
//   armed        : a valid configuration is held
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err,
  output logic               armed
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic               cfg_ok;
  logic               accept;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic               fill_ok;
  logic               match;

  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  // A load in the same cycle owns the edge; the data bit is dropped.
  assign accept   = (state == RUN) && din_valid && !cfg_load;
  assign hist_nxt = {hist[MAX_LEN-2:0], din};
  // Enough bits seen once this one lands: fill + 1 >= len (one extra bit of
  // headroom so fill == MAX_LEN cannot wrap).
  assign fill_ok  = ({1'b0, fill} + 1'b1) >= {1'b0, len_q};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign match = accept && fill_ok && (((hist_nxt ^ pat_q) & len_mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pat_q   <= DEF_PATTERN[MAX_LEN-1:0];
      len_q   <= DEF_LEN_L;
      ovl_q   <= 1'b1;
      hist    <= '0;
      fill    <= '0;
      dout    <= 1'b0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      dout <= 1'b0;
      if (cfg_ok) begin
        state   <= RUN;
        pat_q   <= cfg_pattern;
        len_q   <= cfg_len;
        ovl_q   <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        cfg_err <= 1'b0;
      end else begin
        // Shadow config is kept so a later valid load is the only way back.
        state   <= IDLE;
        cfg_err <= 1'b1;
      end
    end else begin
      dout <= match;
      if (accept) begin
        if (match && !ovl_q) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= hist_nxt;
          if (fill != MAX_LEN_L) begin
            fill <= fill + 1'b1;
          end
        end
      end
    end
  end

  assign armed = (state == RUN);

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog
// Directed bench with a scoreboard: each driven cycle pushes the expected
// dout/match_cnt for the edge that samples it; a monitor pops and compares on
// the falling edge after that sampling edge.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               cnt_clr;
  logic               dout;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;
  logic               armed;

  seq_detect_prog #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .cnt_clr     (cnt_clr),
    .dout        (dout),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  typedef struct {
    int   due;
    logic dout;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consume every expectation due at this falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          check("stale_entry", e.due, cyc);
          check("dout", int'(dout), int'(e.dout));
          check("match_cnt", int'(match_cnt), e.cnt);
        end
      end
    end
  end

  task automatic step(input logic v, input logic d, input logic ld,
                      input logic clr, input logic ed, input int ec);
    exp_t e;
    @(negedge clk);
    din_valid = v;
    din       = v ? d : 1'($urandom_range(0, 1));
    cfg_load  = ld;
    cnt_clr   = clr;
    e.due  = cyc + 1;
    e.dout = ed;
    e.cnt  = ec;
    exp_q.push_back(e);
  endtask

  task automatic bit_in(input logic d, input logic ed, input int ec);
    step(1'b1, d, 1'b0, 1'b0, ed, ec);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len,
                      input logic ovl, input logic clr, input logic v,
                      input int ec);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    step(v, 1'b0, 1'b1, clr, 1'b0, ec);
  endtask

  // Checks the flags right after the edge that consumed the previous step.
  task automatic check_flags(input string tag, input logic e_err, input logic e_armed);
    @(posedge clk);
    #1;
    check({tag, "_cfg_err"}, int'(cfg_err), int'(e_err));
    check({tag, "_armed"}, int'(armed), int'(e_armed));
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; din_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    #12 rst = 1'b0;
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_armed", int'(armed), 1);

    // Default 1110
    bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    // 11110 still one pulse
    step(0, 0, 0, 1, 0, 0);
    bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
    bit_in(0, 1, 1);

    // Overlap: 101 on 1,0,1,0,1 -> two pulses
    load(8'b101, 3, 1'b1, 1'b1, 1'b0, 0);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 1, 1); bit_in(0, 0, 1);
    bit_in(1, 1, 2);
    step(0, 0, 0, 0, 0, 2);
    // Non-overlap: one pulse
    load(8'b101, 3, 1'b0, 1'b1, 1'b0, 0);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 1, 1); bit_in(0, 0, 1);
    bit_in(1, 0, 1);

    // Valid gaps with random din while invalid
    load(8'b1110, 4, 1'b1, 1'b1, 1'b0, 0);
    bit_in(1, 0, 0); step(0, 0, 0, 0, 0, 0);
    bit_in(1, 0, 0); step(0, 0, 0, 0, 0, 0);
    bit_in(1, 0, 0); step(0, 0, 0, 0, 0, 0);
    bit_in(0, 1, 1); step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Invalid load: len=0
    load(8'b1110, 0, 1'b1, 1'b0, 1'b0, 1);
    check_flags("bad_len", 1'b1, 1'b0);
    bit_in(1, 0, 1); bit_in(1, 0, 1); bit_in(1, 0, 1); bit_in(0, 0, 1);
    // Valid reload: 11, len 2
    load(8'b11, 2, 1'b1, 1'b1, 1'b0, 0);
    check_flags("reload", 1'b0, 1'b1);
    bit_in(1, 0, 0); bit_in(1, 1, 1);
    // Mid-stream reload of 110 after 2 bits, with a data bit offered alongside
    load(8'b110, 3, 1'b1, 1'b0, 1'b0, 1);
    bit_in(1, 0, 1); bit_in(1, 0, 1);
    load(8'b110, 3, 1'b1, 1'b0, 1'b1, 1);
    bit_in(0, 0, 1);
    bit_in(1, 0, 1); bit_in(1, 0, 1); bit_in(0, 1, 2);

    // Saturation with CNT_W=2: five matches -> 3
    load(8'b11, 2, 1'b1, 1'b1, 1'b0, 0);
    bit_in(1, 0, 0); bit_in(1, 1, 1); bit_in(1, 1, 2); bit_in(1, 1, 3);
    bit_in(1, 1, 3); bit_in(1, 1, 3);

    // Asynchronous reset while dout=1
    @(negedge clk);
    #1;
    check("pre_rst_dout", int'(dout), 1);
    check("pre_rst_cnt", int'(match_cnt), 3);
    din_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_cnt", int'(match_cnt), 0);
    check("async_rst_armed", int'(armed), 1);
    #1 rst = 1'b0;

    // Default 1110 restored (pattern 11 would fire on the second 1)
    bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(0, 1, 1);
    // cnt_clr on a match edge wins
    bit_in(1, 0, 1); bit_in(1, 0, 1); bit_in(1, 0, 1);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Programmable serial sequence detector; the parametrised successor of the team's fixed-pattern Moore detector.
- Pattern bits, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded at run time.
- Adds an input-valid qualifier, a saturating match counter and config-error flagging.
- Sits on a serial bit stream feeding protocol/framing logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- cfg_load  input  1  one-cycle strobe; capture cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history flushed after a match.
- din_valid  input  1  din is sampled only when high.
- din  input  1  serial data bit.
- cnt_clr  input  1  synchronous clear of match_cnt.
- dout  output  1  match pulse, registered (Moore).
- match_cnt  output  CNT_W  saturating count of matches.
- cfg_err  output  1  sticky flag: last load was invalid.
- armed  output  1  high when a valid configuration is held.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Values during reset:
  - Outputs: dout=0, match_cnt=0, cfg_err=0, armed=1.
  - Shadow config = pattern 'b1110 zero-extended, len=4, overlap=1.
  - hist=0, fill=0. State = RUN.
- Registers:
  - hist[MAX_LEN-1:0]: shift register. On an accepted bit, hist <= {hist[MAX_LEN-2:0], din}.
  - fill: 0..MAX_LEN. Counts bits accepted since the last flush; saturates at MAX_LEN.
- States:
  - IDLE: no valid config.
  - RUN: detecting.
- Transitions:
  - Valid cfg_load (1 <= cfg_len <= MAX_LEN): from any state go to RUN. Capture the config. Clear hist, fill and cfg_err. dout=0 next cycle. armed=1.
  - Invalid cfg_load (cfg_len==0 or > MAX_LEN): go to IDLE. Set cfg_err=1. armed=0. Shadow config unchanged.
  - In IDLE, din is ignored and dout stays 0.
- Match condition, evaluated in RUN with din_valid=1:
  - Form the next hist value.
  - Match when fill+1 >= len and the low len bits of the next hist equal pattern[len-1:0]. Bits above len are masked.
- dout timing:
  - dout is registered. It is high exactly in the cycle after the clock edge that sampled the completing bit. This is a one-cycle latency, as in a Moore state.
  - dout=0 in any cycle with no match on the preceding edge, including din_valid=0 cycles.
- After a match:
  - Overlap mode: fill advances normally.
  - Non-overlap mode: fill <= 0 and hist <= 0, so the next match needs len fresh bits.
- match_cnt:
  - Increments on each match edge.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; result is 0.
- Simultaneous events:
  - cfg_load with din_valid in the same cycle: the config wins and din is discarded.
  - cfg_load does not clear match_cnt.
- Reset mid-pattern: partial history is lost and dout drops immediately (asynchronous).
- No combinational path from din to dout.

Decomposition:
- Shared package seq_detect_pkg holds:
  - state enum {IDLE, RUN};
  - default pattern constant 'b1110 and default length 4.
- Natural sub-module: sat_counter (CNT_W wide, inc/clr, saturating), reusable elsewhere.
- Match/mask logic and state machine stay in the top block.

Test Plan:
- Default after reset: din 1,1,1,0 with valid every cycle. Expect dout=1 only in the cycle after the 0 is sampled, and match_cnt=1. Input 1,1,1,1,0 also gives exactly one pulse.
- Overlap mode: load pattern 'b101, len=3, overlap=1; feed 1,0,1,0,1. Expect two dout pulses (after bits 3 and 5) and match_cnt=2. Same stream with overlap=0: one pulse, match_cnt=1.
- Valid gaps: default pattern with din_valid low between every bit (din toggled randomly while low). Expect exactly one match. dout is high for one cycle only and never while valid is low.
- Invalid config and mid-stream reload:
  - Load len=0: expect cfg_err=1, armed=0, no matches on 1,1,1,0.
  - Reload len=2, pattern 'b11: cfg_err clears; 1,1 then gives a match.
  - Reload after 2 bits of a 3-bit pattern: the partial match is discarded.
- Counter: CNT_W=2; produce 5 matches and expect match_cnt=3. cnt_clr together with a match edge gives match_cnt=0.
- Reset: assert rst asynchronously between edges while dout=1. dout=0 and match_cnt=0 immediately; the default 1110 config is restored.
